fifo_port_arbiter: RTL and testbench

//  Shares one fifo instance among two writer ports (wr0, wr1) and one reader port (rd).

---
 rtl/fifo_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_fifo_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_port_arbiter.sv
// Arbitrates two writer ports and one reader port onto a single shared fifo.
// Round-robin grant order wr0 -> wr1 -> rd; one push or pop per grant, then waits out fifo busy.
module fifo_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  wr0_req_i,
    input  logic [DATA_WIDTH-1:0] wr0_data_i,
    output logic                  wr0_ack_o,
    input  logic                  wr1_req_i,
    input  logic [DATA_WIDTH-1:0] wr1_data_i,
    output logic                  wr1_ack_o,
    input  logic                  rd_req_i,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  fifo_push_o,
    output logic                  fifo_pop_o,
    output logic [DATA_WIDTH-1:0] fifo_data_in_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_out_i,
    input  logic                  fifo_busy_i,
    input  logic                  fifo_full_i,
    input  logic                  fifo_empty_i,
    output logic [CNT_WIDTH-1:0]  push_total_o,
    output logic [CNT_WIDTH-1:0]  pop_total_o
);
    // state | meaning: IDLE arbitrate | ISSUE pulses out | SETTLE busy ignored | WAIT hold while busy
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT} state_t;
    typedef enum logic [1:0] {G_WR0, G_WR1, G_RD} grant_t;

    state_t                state_q, state_d;
    grant_t                last_q, last_d;
    logic                  wr0_ack_q, wr0_ack_d;
    logic                  wr1_ack_q, wr1_ack_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  push_q, push_d;
    logic                  pop_q, pop_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;
    logic [CNT_WIDTH-1:0]  push_total_q, push_total_d;
    logic [CNT_WIDTH-1:0]  pop_total_q, pop_total_d;
    logic [2:0]            elig;
    logic [2:0]            pick;

    // elig/pick bit order is {rd, wr1, wr0}; a busy fifo blocks every requester
    always_comb begin
        elig = 3'b000;
        if (!fifo_busy_i) begin
            elig[0] = wr0_req_i & ~fifo_full_i;
            elig[1] = wr1_req_i & ~fifo_full_i;
            elig[2] = rd_req_i & ~fifo_empty_i;
        end
        pick = 3'b000;
        case (last_q)
            G_WR0: begin
                if (elig[1])      pick = 3'b010;
                else if (elig[2]) pick = 3'b100;
                else if (elig[0]) pick = 3'b001;
            end
            G_WR1: begin
                if (elig[2])      pick = 3'b100;
                else if (elig[0]) pick = 3'b001;
                else if (elig[1]) pick = 3'b010;
            end
            default: begin
                if (elig[0])      pick = 3'b001;
                else if (elig[1]) pick = 3'b010;
                else if (elig[2]) pick = 3'b100;
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        wr0_ack_d      = 1'b0;
        wr1_ack_d      = 1'b0;
        rd_valid_d     = 1'b0;
        push_d         = 1'b0;
        pop_d          = 1'b0;
        rd_data_d      = rd_data_q;
        fifo_data_in_d = fifo_data_in_q;
        push_total_d   = push_total_q;
        pop_total_d    = pop_total_q;
        case (state_q)
            S_IDLE: begin
                if (pick != 3'b000) begin
                    state_d = S_ISSUE;
                    if (pick[0]) begin
                        last_d         = G_WR0;
                        wr0_ack_d      = 1'b1;
                        push_d         = 1'b1;
                        fifo_data_in_d = wr0_data_i;
                        push_total_d   = push_total_q + CNT_WIDTH'(1);
                    end else if (pick[1]) begin
                        last_d         = G_WR1;
                        wr1_ack_d      = 1'b1;
                        push_d         = 1'b1;
                        fifo_data_in_d = wr1_data_i;
                        push_total_d   = push_total_q + CNT_WIDTH'(1);
                    end else begin
                        last_d      = G_RD;
                        rd_valid_d  = 1'b1;
                        pop_d       = 1'b1;
                        rd_data_d   = fifo_data_out_i;
                        pop_total_d = pop_total_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_ISSUE:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (!fifo_busy_i) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            last_q         <= G_RD;
            wr0_ack_q      <= 1'b0;
            wr1_ack_q      <= 1'b0;
            rd_valid_q     <= 1'b0;
            push_q         <= 1'b0;
            pop_q          <= 1'b0;
            rd_data_q      <= '0;
            fifo_data_in_q <= '0;
            push_total_q   <= '0;
            pop_total_q    <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            wr0_ack_q      <= wr0_ack_d;
            wr1_ack_q      <= wr1_ack_d;
            rd_valid_q     <= rd_valid_d;
            push_q         <= push_d;
            pop_q          <= pop_d;
            rd_data_q      <= rd_data_d;
            fifo_data_in_q <= fifo_data_in_d;
            push_total_q   <= push_total_d;
            pop_total_q    <= pop_total_d;
        end
    end

    assign wr0_ack_o      = wr0_ack_q;
    assign wr1_ack_o      = wr1_ack_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = rd_data_q;
    assign fifo_push_o    = push_q;
    assign fifo_pop_o     = pop_q;
    assign fifo_data_in_o = fifo_data_in_q;
    assign push_total_o   = push_total_q;
    assign pop_total_o    = pop_total_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Random-traffic bench: fifo device model, transaction-level arbiter reference model and a
// scoreboard monitor that checks every grant pulse, its cycle, its data and the totals.
module tb_fifo_port_arbiter;
    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int DEPTH = 4;
    localparam int NCYC  = 4000;

    logic          clock, reset;
    logic          wr0_req, wr1_req, rd_req;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_ack, wr1_ack, rd_valid;
    logic [DW-1:0] rd_data, fifo_data_in, fifo_data_out;
    logic          fifo_push, fifo_pop, fifo_busy, fifo_full, fifo_empty;
    logic [CW-1:0] push_total, pop_total;

    fifo_port_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clock_i(clock), .reset_i(reset),
        .wr0_req_i(wr0_req), .wr0_data_i(wr0_data), .wr0_ack_o(wr0_ack),
        .wr1_req_i(wr1_req), .wr1_data_i(wr1_data), .wr1_ack_o(wr1_ack),
        .rd_req_i(rd_req), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .fifo_push_o(fifo_push), .fifo_pop_o(fifo_pop),
        .fifo_data_in_o(fifo_data_in), .fifo_data_out_i(fifo_data_out),
        .fifo_busy_i(fifo_busy), .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
        .push_total_o(push_total), .pop_total_o(pop_total)
    );

    typedef struct {
        int            cyc;
        logic [4:0]    pulses;  // {wr0_ack, wr1_ack, rd_valid, fifo_push, fifo_pop}
        logic [DW-1:0] data;
        logic [CW-1:0] ptot;
        logic [CW-1:0] otot;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            seen_w0 = 0, seen_w1 = 0, seen_rd = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: consumes one scoreboard entry per observed grant pulse
    logic [4:0]    mon_pulses;
    logic [DW-1:0] mon_data;
    exp_t          mon_e;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            mon_pulses = {wr0_ack, wr1_ack, rd_valid, fifo_push, fifo_pop};
            if (reset) begin
                checks++;
                if (mon_pulses != 5'b0 || push_total != '0 || pop_total != '0 ||
                    rd_data != '0 || fifo_data_in != '0) begin
                    errors++;
                    $display("FAIL reset_state cyc=%0d got pulses=%b ptot=%0d otot=%0d rd_data=%h data_in=%h, need all zero",
                             cyc, mon_pulses, push_total, pop_total, rd_data, fifo_data_in);
                end
            end
            if (mon_pulses != 5'b0) begin
                checks++;
                if (wr0_ack) seen_w0++;
                if (wr1_ack) seen_w1++;
                if (rd_valid) seen_rd++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant cyc=%0d got pulses=%b, need none", cyc, mon_pulses);
                end else begin
                    mon_e    = sb.pop_front();
                    mon_data = mon_e.pulses[2] ? rd_data : fifo_data_in;
                    if (mon_e.cyc != cyc || mon_e.pulses != mon_pulses || mon_e.data != mon_data ||
                        mon_e.ptot != push_total || mon_e.otot != pop_total) begin
                        errors++;
                        $display("FAIL grant got cyc=%0d pulses=%b data=%h ptot=%0d otot=%0d need cyc=%0d pulses=%b data=%h ptot=%0d otot=%0d",
                                 cyc, mon_pulses, mon_data, push_total, pop_total,
                                 mon_e.cyc, mon_e.pulses, mon_e.data, mon_e.ptot, mon_e.otot);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_grant cyc=%0d got pulses=%b need pulses=%b", cyc, mon_pulses, sb[0].pulses);
                void'(sb.pop_front());
            end
        end
    end

    // Stimulus, fifo device model and reference model, all evaluated at the falling edge
    logic [DW-1:0] dq[$];
    logic [DW-1:0] mq[$];
    int            bcnt, rst_left, last, avail, settle_done, g, rd_rate;
    bit            waiting;
    logic [2:0]    elig;
    logic [CW-1:0] mptot, motot;
    exp_t          e;

    initial begin
        reset = 1'b1;
        wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
        wr0_data = '0; wr1_data = '0;
        fifo_busy = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1; fifo_data_out = '0;
        bcnt = 0; rst_left = 2; last = 2; avail = 0; settle_done = 0; waiting = 1'b0;
        mptot = '0; motot = '0;
        for (int n = 0; n < NCYC; n++) begin
            @(negedge clock);
            // fifo device: 2-cycle busy after push, 1-cycle after pop, rare spurious busy
            fifo_busy = (bcnt > 0) || ($urandom_range(0, 24) == 0);
            if (bcnt > 0) bcnt--;
            if (fifo_push) begin
                if (dq.size() < DEPTH) dq.push_back(fifo_data_in);
                bcnt = 2;
            end
            if (fifo_pop) begin
                if (dq.size() > 0) void'(dq.pop_front());
                bcnt = 1;
            end
            fifo_full     = (dq.size() == DEPTH);
            fifo_empty    = (dq.size() == 0);
            fifo_data_out = (dq.size() > 0) ? dq[0] : DW'($urandom);

            // clients; reader rate varies by phase so the fifo both fills and drains
            rd_rate = ((n / 400) % 3 == 0) ? 8 : ((n / 400) % 3 == 1) ? 1 : 3;
            if (n >= NCYC - 30) begin
                wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
            end else begin
                if (wr0_ack) begin
                    if ($urandom_range(0, 1) == 0) wr0_req = 1'b0; else wr0_data = DW'($urandom);
                end else if (!wr0_req && $urandom_range(0, 3) == 0) begin
                    wr0_req = 1'b1; wr0_data = DW'($urandom);
                end
                if (wr1_ack) begin
                    if ($urandom_range(0, 1) == 0) wr1_req = 1'b0; else wr1_data = DW'($urandom);
                end else if (!wr1_req && $urandom_range(0, 3) == 0) begin
                    wr1_req = 1'b1; wr1_data = DW'($urandom);
                end
                if (rd_valid && $urandom_range(0, 1) == 0) rd_req = 1'b0;
                else if (!rd_req && $urandom_range(0, rd_rate) == 0) rd_req = 1'b1;
            end

            if (rst_left == 0 && !reset && n > 20 && n < NCYC - 30 && $urandom_range(0, 199) == 0)
                rst_left = $urandom_range(1, 2);
            if (rst_left > 0) begin
                reset = 1'b1;
                rst_left--;
            end else begin
                reset = 1'b0;
            end

            // reference: a grant at t is followed by pulses at t+1; the arbiter is back to
            // arbitrating the cycle after the first non-busy cycle at or beyond t+3
            if (reset) begin
                dq.delete(); mq.delete(); bcnt = 0;
                mptot = '0; motot = '0; last = 2; waiting = 1'b0; avail = cyc + 1;
            end else begin
                if (waiting && cyc >= settle_done && !fifo_busy) begin
                    waiting = 1'b0;
                    avail   = cyc + 1;
                end
                if (!waiting && cyc >= avail && !fifo_busy) begin
                    elig[0] = wr0_req && (mq.size() < DEPTH);
                    elig[1] = wr1_req && (mq.size() < DEPTH);
                    elig[2] = rd_req && (mq.size() > 0);
                    g = -1;
                    for (int k = 1; k <= 3; k++)
                        if (g < 0 && elig[(last + k) % 3]) g = (last + k) % 3;
                    if (g >= 0) begin
                        e.cyc = cyc + 1;
                        if (g == 2) begin
                            e.pulses = 5'b00101;
                            e.data   = mq.pop_front();
                            motot    = motot + 1'b1;
                        end else begin
                            e.pulses = (g == 0) ? 5'b10010 : 5'b01010;
                            e.data   = (g == 0) ? wr0_data : wr1_data;
                            mq.push_back(e.data);
                            mptot    = mptot + 1'b1;
                        end
                        e.ptot = mptot;
                        e.otot = motot;
                        sb.push_back(e);
                        last        = g;
                        waiting     = 1'b1;
                        settle_done = cyc + 3;
                    end
                end
            end
        end
        repeat (3) @(negedge clock);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending need 0", sb.size());
        end
        checks++;
        if (seen_w0 < 20 || seen_w1 < 20 || seen_rd < 20) begin
            errors++;
            $display("FAIL grant_activity got wr0=%0d wr1=%0d rd=%0d need each >= 20", seen_w0, seen_w1, seen_rd);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
